// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus between decode, bypass sources and the ALU operand stage.
// The master drives decode/bypass/ready; the slave (the stage) drives the registered outputs.
interface alu_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] imm;
  logic            use_imm;
  logic [2:0]      uop_in;
  logic            f7_in;
  logic [4:0]      rd_in;
  logic            fwd_ex_valid;
  logic [4:0]      fwd_ex_rd;
  logic [XLEN-1:0] fwd_ex_data;
  logic            fwd_wb_valid;
  logic [4:0]      fwd_wb_rd;
  logic [XLEN-1:0] fwd_wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      uop;
  logic            f7;
  logic [4:0]      rd;

  modport master (
    output in_valid, flush, rs1_data, rs2_data, rs1_addr, rs2_addr, imm, use_imm,
           uop_in, f7_in, rd_in, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, op1, op2, uop, f7, rd
  );

  modport slave (
    input  in_valid, flush, rs1_data, rs2_data, rs1_addr, rs2_addr, imm, use_imm,
           uop_in, f7_in, rd_in, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, op1, op2, uop, f7, rd
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: bypass selection, immediate muxing and a one-entry
// valid/ready register slice feeding the ALU.
module alu_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_operand_stage_if.slave bus
);

  logic            capture;
  logic [XLEN-1:0] op1_sel;
  logic [XLEN-1:0] op2_sel;
  logic            f7_sel;

  // x0 is hardwired to zero, so a bypass hit on index 0 must never win.
  function automatic logic [XLEN-1:0] bypass(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_valid,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_valid,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (addr != '0) begin
      if (ex_valid && ex_rd == addr)      r = ex_data;
      else if (wb_valid && wb_rd == addr) r = wb_data;
    end
    return r;
  endfunction

  always_comb begin
    bus.in_ready = rst_n & (~bus.out_valid | bus.out_ready) & ~bus.flush;
    capture      = bus.in_valid & bus.in_ready;
  end

  always_comb begin
    op1_sel = bypass(bus.rs1_addr, bus.rs1_data,
                     bus.fwd_ex_valid, bus.fwd_ex_rd, bus.fwd_ex_data,
                     bus.fwd_wb_valid, bus.fwd_wb_rd, bus.fwd_wb_data);
    op2_sel = bypass(bus.rs2_addr, bus.rs2_data,
                     bus.fwd_ex_valid, bus.fwd_ex_rd, bus.fwd_ex_data,
                     bus.fwd_wb_valid, bus.fwd_wb_rd, bus.fwd_wb_data);
    if (bus.use_imm) op2_sel = bus.imm;
    // ADDI shares funct3 with ADD/SUB but has no funct7; force add.
    f7_sel = (bus.use_imm && bus.uop_in == 3'b000) ? 1'b0 : bus.f7_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.op1       <= '0;
      bus.op2       <= '0;
      bus.uop       <= '0;
      bus.f7        <= 1'b0;
      bus.rd        <= '0;
    end else begin
      if (bus.flush)         bus.out_valid <= 1'b0;
      else if (capture)      bus.out_valid <= 1'b1;
      else if (bus.out_ready) bus.out_valid <= 1'b0;

      if (capture) begin
        bus.op1 <= op1_sel;
        bus.op2 <= op2_sel;
        bus.uop <= bus.uop_in;
        bus.f7  <= f7_sel;
        bus.rd  <= bus.rd_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a behavioural model.
module tb_alu_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_operand_stage_if #(.XLEN(32)) bus ();

  alu_operand_stage #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state of the held instruction.
  logic        m_valid;
  logic [31:0] m_op1, m_op2;
  logic [2:0]  m_uop;
  logic        m_f7;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] source(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return rf;
    if (bus.fwd_ex_valid && bus.fwd_ex_rd == addr) return bus.fwd_ex_data;
    if (bus.fwd_wb_valid && bus.fwd_wb_rd == addr) return bus.fwd_wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_uop = 0; m_f7 = 0; m_rd = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, m_valid});
    check({pfx, ".op1"}, bus.op1, m_op1);
    check({pfx, ".op2"}, bus.op2, m_op2);
    check({pfx, ".uop"}, {29'b0, bus.uop}, {29'b0, m_uop});
    check({pfx, ".f7"}, {31'b0, bus.f7}, {31'b0, m_f7});
    check({pfx, ".rd"}, {27'b0, bus.rd}, {27'b0, m_rd});
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.flush = 0; bus.rs1_data = 0; bus.rs2_data = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0; bus.imm = 0; bus.use_imm = 0;
    bus.uop_in = 0; bus.f7_in = 0; bus.rd_in = 0;
    bus.fwd_ex_valid = 0; bus.fwd_ex_rd = 0; bus.fwd_ex_data = 0;
    bus.fwd_wb_valid = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 0;
    bus.out_ready = 1;
  endtask

  // One clock: check combinational ready, advance the model over the edge, check registers.
  task automatic step(input string pfx);
    logic        rdy, cap;
    logic        n_valid;
    logic [31:0] n_op1, n_op2;
    logic [2:0]  n_uop;
    logic        n_f7;
    logic [4:0]  n_rd;
    #1;
    rdy = rst_n && (!m_valid || bus.out_ready) && !bus.flush;
    check({pfx, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, rdy});
    cap = bus.in_valid && rdy;
    n_valid = bus.flush ? 1'b0 : cap ? 1'b1 : bus.out_ready ? 1'b0 : m_valid;
    n_op1 = m_op1; n_op2 = m_op2; n_uop = m_uop; n_f7 = m_f7; n_rd = m_rd;
    if (cap) begin
      n_op1 = source(bus.rs1_addr, bus.rs1_data);
      n_op2 = bus.use_imm ? bus.imm : source(bus.rs2_addr, bus.rs2_data);
      n_uop = bus.uop_in;
      n_f7  = (bus.use_imm && bus.uop_in == 0) ? 1'b0 : bus.f7_in;
      n_rd  = bus.rd_in;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_op1 = n_op1; m_op2 = n_op2;
    m_uop = n_uop; m_f7 = n_f7; m_rd = n_rd;
    check_outputs(pfx);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle();
    model_reset();
    rst_n = 0;
    #2;
    check_outputs("reset");
    check("reset.in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Basic ADD captured on the first edge after reset release.
    bus.in_valid = 1; bus.rs1_data = 5; bus.rs2_data = 7; bus.rs1_addr = 1;
    bus.rs2_addr = 2; bus.rd_in = 4;
    step("add");
    check("add.op1_const", bus.op1, 32'd5);
    check("add.op2_const", bus.op2, 32'd7);

    // ADDI with f7_in set must not become a subtract.
    @(negedge clk);
    bus.use_imm = 1; bus.imm = 32'hFFFF_FFFF; bus.f7_in = 1; bus.uop_in = 3'b000;
    step("addi");
    check("addi.op2_const", bus.op2, 32'hFFFF_FFFF);
    check("addi.f7_const", {31'b0, bus.f7}, 32'd0);

    // SRAI keeps f7.
    @(negedge clk);
    bus.uop_in = 3'b101;
    step("srai");
    check("srai.f7_const", {31'b0, bus.f7}, 32'd1);

    // Both bypasses hit: ex wins.
    @(negedge clk);
    idle();
    bus.in_valid = 1; bus.rs1_addr = 3; bus.rs1_data = 32'h11;
    bus.fwd_ex_valid = 1; bus.fwd_ex_rd = 3; bus.fwd_ex_data = 32'hAA;
    bus.fwd_wb_valid = 1; bus.fwd_wb_rd = 3; bus.fwd_wb_data = 32'hBB;
    step("dbl_bypass");
    check("dbl_bypass.op1_const", bus.op1, 32'hAA);

    // x0 is never forwarded.
    @(negedge clk);
    bus.rs1_addr = 0; bus.rs1_data = 0; bus.fwd_ex_rd = 0; bus.fwd_ex_data = 32'h55;
    bus.fwd_wb_rd = 0;
    step("x0");
    check("x0.op1_const", bus.op1, 32'd0);

    // Backpressure: hold a valid instruction for 3 cycles, then back-to-back capture.
    @(negedge clk);
    idle();
    bus.in_valid = 1; bus.rs1_data = 32'h1234; bus.rd_in = 7;
    step("bp_load");
    @(negedge clk);
    bus.out_ready = 0; bus.rs1_data = 32'h5678; bus.rd_in = 9;
    for (int unsigned i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp_hold.op1_const", bus.op1, 32'h1234);
      @(negedge clk);
    end
    bus.out_ready = 1;
    step("bp_release");
    check("bp_release.op1_const", bus.op1, 32'h5678);
    check("bp_release.valid_const", {31'b0, bus.out_valid}, 32'd1);

    // Flush kills the held and the offered instruction.
    @(negedge clk);
    bus.flush = 1; bus.rs1_data = 32'h9999; bus.out_ready = 0;
    step("flush");
    check("flush.valid_const", {31'b0, bus.out_valid}, 32'd0);
    check("flush.op1_kept", bus.op1, 32'h5678);

    // Asynchronous reset mid-cycle with a valid instruction held.
    @(negedge clk);
    idle();
    bus.in_valid = 1; bus.rs1_data = 32'hDEAD; bus.out_ready = 0;
    step("pre_rst");
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step("post_rst");

    // Randomized traffic with a small register space to provoke bypass hits.
    for (int unsigned n = 0; n < 500; n++) begin
      @(negedge clk);
      bus.in_valid     = $urandom_range(0, 3) != 0;
      bus.flush        = $urandom_range(0, 15) == 0;
      bus.out_ready    = $urandom_range(0, 3) != 0;
      bus.rs1_data     = $urandom;
      bus.rs2_data     = $urandom;
      bus.rs1_addr     = 5'($urandom_range(0, 3));
      bus.rs2_addr     = 5'($urandom_range(0, 3));
      bus.imm          = $urandom;
      bus.use_imm      = $urandom_range(0, 1) == 1;
      bus.uop_in       = 3'($urandom_range(0, 7));
      bus.f7_in        = $urandom_range(0, 1) == 1;
      bus.rd_in        = 5'($urandom_range(0, 31));
      bus.fwd_ex_valid = $urandom_range(0, 1) == 1;
      bus.fwd_ex_rd    = 5'($urandom_range(0, 3));
      bus.fwd_ex_data  = $urandom;
      bus.fwd_wb_valid = $urandom_range(0, 1) == 1;
      bus.fwd_wb_rd    = 5'($urandom_range(0, 3));
      bus.fwd_wb_data  = $urandom;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  decode presents a valid instruction.
REQ-005 in_ready  output  1  stage can accept the instruction this cycle.
REQ-006 flush  input  1  kill the held instruction and any instruction offered this cycle.
REQ-007 rs1_data, rs2_data  input  32 each  register-file read data.
REQ-008 rs1_addr, rs2_addr  input  5 each  source register indices.
REQ-009 imm  input  32  sign-extended immediate.
REQ-010 use_imm  input  1  op2 source select: 1 selects imm, 0 selects rs2.
REQ-011 uop_in  input  3  ALU micro-op, funct3 encoding.
REQ-012 f7_in  input  1  funct7[5] bit.
REQ-013 rd_in  input  5  destination register index.
REQ-014 fwd_ex_valid, fwd_ex_rd, fwd_ex_data  input  1/5/32  bypass from the ALU result of the older instruction.
REQ-015 fwd_wb_valid, fwd_wb_rd, fwd_wb_data  input  1/5/32  bypass from the writeback stage.
REQ-016 out_valid  output  1  op1, op2, uop, f7 and rd hold a valid instruction.
REQ-017 out_ready  input  1  the ALU and downstream stages consume the instruction this cycle.
REQ-018 op1, op2  output  32 each  registered ALU operands.
REQ-019 uop, f7  output  3/1  registered ALU control.
REQ-020 rd  output  5  registered destination index.

Function
REQ-021 in_ready SHALL equal (~out_valid | out_ready) & ~flush, as a combinational function.
REQ-022 A capture SHALL occur when in_valid & in_ready; on capture all output registers load on the same edge, giving 1-cycle latency.
REQ-023 When no capture occurs, op1, op2, uop, f7 and rd SHALL hold their values, so they stay stable while out_valid & ~out_ready.
REQ-024 out_valid next-state rules:
- flush gives 0;
- otherwise a capture gives 1;
- otherwise out_ready gives 0;
- otherwise out_valid holds.
REQ-025 Simultaneous consume and capture (out_valid & out_ready & in_valid) SHALL give back-to-back transfer with no bubble.
REQ-026 flush SHALL have priority over capture and consume; the offered instruction is dropped and is not accepted.
REQ-027 Operand A SHALL be selected in this priority order:
- fwd_ex_data when fwd_ex_valid and fwd_ex_rd == rs1_addr and rs1_addr != 0;
- otherwise fwd_wb_data under the same conditions using the wb inputs;
- otherwise rs1_data.
REQ-028 Operand B SHALL be selected by the same priority against rs2_addr; when use_imm=1 it is replaced by imm.
REQ-029 A source index of x0 SHALL never be forwarded; rs*_data is used for x0 regardless of any bypass hit.
REQ-030 f7 SHALL be captured as 0 when use_imm=1 and uop_in=000, so ADDI never subtracts.
REQ-031 For all other captures, f7 SHALL be captured as f7_in, which keeps SRAI versus SRLI correct.
REQ-032 The stage SHALL do no arithmetic; the operand paths are pure multiplexing into 32-bit registers.

Reset
REQ-033 While rst_n=0, out_valid, op1, op2, uop, f7 and rd SHALL be 0, taking effect asynchronously.
REQ-034 While rst_n=0, in_ready SHALL be 0.
REQ-035 Reset asserted mid-transfer SHALL discard the held instruction with no partial update.
REQ-036 After rst_n deasserts, the first capture SHALL be possible on the first rising clk edge.

Verification
REQ-037 Basic ADD: rs1_data=5, rs2_data=7, uop_in=000, use_imm=0, no bypass.
- Response: next cycle op1=5, op2=7, out_valid=1.
REQ-038 ADDI with f7_in=1: use_imm=1, imm=0xFFFFFFFF, uop_in=000.
- Response: op2=0xFFFFFFFF, f7=0.
REQ-039 Double bypass hit: rs1_addr=3, fwd_ex_rd=3 with data 0xAA, fwd_wb_rd=3 with data 0xBB, both valid.
- Response: op1=0xAA.
REQ-040 x0 bypass: rs1_addr=0, fwd_ex_rd=0 with data 0x55, rs1_data=0.
- Response: op1=0.
REQ-041 Backpressure: out_ready=0 for 3 cycles with in_valid=1.
- Response: in_ready=0, outputs unchanged.
- Then out_ready=1: the next instruction is captured on the same edge as the consume, with no bubble.
REQ-042 Flush: flush=1 while out_valid=1 and in_valid=1.
- Response: next cycle out_valid=0 and the offered instruction is lost.
- Also: async rst_n low mid-cycle gives all outputs 0 immediately.
